delay_line_ctrl: RTL
====================

Name: delay_line_ctrl

Overview:
Sequencer for the 16-bit x 29280-word delay memory (memory_mod) that makes it a circular echo/delay line for the guitar FX chain.
- Per accepted input sample: reads the delayed sample from (write pointer - delay), writes input + scaled feedback at the write pointer, emits the delayed (wet) sample.
- Sits between the sample-rate front end and memory_mod. It is the memory's only master.

Parameters:
DEPTH, 29280, number of valid memory words; addresses wrap at DEPTH-1 -> 0
AW, 15, memory address width
DW, 16, sample width (signed two's complement)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  input sample valid
in_ready  out  1  controller can accept a sample
sample_in  in  DW  dry input sample, signed
delay_len  in  AW  delay in samples, sampled at accept
fb_gain  in  8  feedback gain, unsigned, gain = fb_gain/256
out_valid  out  1  one-cycle pulse, sample_out valid
sample_out  out  DW  delayed (wet) sample, signed
busy  out  1  high in any state other than IDLE
mem_w_en  out  1  to memory_mod w_en
mem_w_addr  out  AW  to memory_mod w_addr
mem_d_in  out  DW  to memory_mod d_in
mem_r_addr  out  AW  to memory_mod r_addr
mem_d_out  in  DW  from memory_mod d_out; valid 1 cycle after mem_r_addr is presented

Behaviour:
- Reset (rst_n low at a posedge):
  - Outputs: state IDLE (CLEAR when fill is enabled), wr_ptr=0, out_valid=0, sample_out=0, all mem_* outputs 0.
  - mem_w_en is gated with rst_n combinationally, so no write occurs in any cycle where rst_n=0, including reset mid-operation.
- FSM states: IDLE -> RD -> WR -> IDLE. Moore outputs only; in_ready = (state==IDLE).
- IDLE: a sample is accepted on the edge where in_valid && in_ready. At that edge the controller latches sample_in, fb_gain and the clamped delay d, and moves to RD.
- Delay clamp: d = 1 if delay_len==0; d = DEPTH-1 if delay_len>=DEPTH; otherwise d = delay_len.
- RD: mem_r_addr = wr_ptr - d. If the result is negative, add DEPTH. No write in this state. Next state WR.
- WR:
  - Memory drive: mem_d_out holds the delayed sample y. mem_w_en=1, mem_w_addr=wr_ptr, mem_d_in = sat16(x + ((y * fb_gain) >>> 8)).
  - Arithmetic: y*fb_gain is a 24-bit signed product, shifted right arithmetically. The sum is formed at 17 bits and saturated to [-32768, 32767].
  - On exit: sample_out<=y, out_valid<=1 for exactly the next cycle, and wr_ptr<=(wr_ptr==DEPTH-1)?0:wr_ptr+1.
- Latency and throughput: out_valid is high in the cycle after the 3rd edge following acceptance. in_ready is high in that same cycle, giving one sample per 3 clocks.
- Busy handling: in_valid while busy is ignored. Upstream holds the sample until in_ready.
- mem_r_addr and mem_w_addr are never equal during a WR cycle, because d >= 1.
- wr_ptr never reaches DEPTH..2^AW-1.

Optional Feature:
DELAY_LINE_CTRL_FILL_EN
- Defined:
  - After reset the FSM enters CLEAR and writes 0 to addresses 0..DEPTH-1, one per cycle (mem_w_en=1, mem_d_in=0). in_ready=0 and busy=1 during CLEAR.
  - Enters IDLE after writing address DEPTH-1, i.e. DEPTH cycles after reset release.
  - Reset during CLEAR restarts the sweep at address 0.
- Undefined: no CLEAR state. Reset goes straight to IDLE; reads of unwritten locations return whatever the memory holds.

Decomposition:
- Package delay_line_pkg:
  - state enum {IDLE, RD, WR, CLEAR}
  - DEPTH/AW/DW default constants
  - sat16 function (17-bit to 16-bit signed saturation)
- One sub-module: delay_addr_gen, which computes the clamped delay and the wrapped read address from wr_ptr and delay_len.

Test Plan:
- FILL_EN on, reset, wait DEPTH cycles -> in_ready rises exactly DEPTH cycles after rst_n=1; memory words 0, 100 and 29279 read 0.
- fb_gain=0, delay_len=4, samples 1..10 -> sample_out sequence 0,0,0,0,1,2,3,4,5,6; each out_valid occurs 3 edges after its accept.
- Feedback saturation: memory y=0x7FFF, x=0x7FFF, fb_gain=255 -> mem_d_in=0x7FFF. With y=0x8000, x=0x8000, fb_gain=255 -> mem_d_in=0x8000.
- Wrap:
  - wr_ptr=29278, delay_len=29279 -> mem_r_addr=29279; next write lands at 29279, then wr_ptr=0.
  - delay_len=0x7FFF clamps -> mem_r_addr=(wr_ptr+1) mod 29280.
- delay_len=0 -> behaves as delay 1: input 5 then 9 -> second output is 5.
- Reset mid-op: rst_n=0 during a WR cycle -> mem_w_en=0 in that cycle; after the edge out_valid=0, wr_ptr=0 and state IDLE (CLEAR with FILL_EN); in_valid held high during busy is not double-accepted.

Source files
------------

// File: rtl/delay_line_pkg.sv
// Shared types and constants for the delay-line sequencer.
// Includes the 17-to-16-bit saturation used on the feedback path.
package delay_line_pkg;

  localparam int DL_DEPTH = 29280;
  localparam int DL_AW    = 15;
  localparam int DL_DW    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD    = 2'd1,
    WR    = 2'd2,
    CLEAR = 2'd3
  } state_e;

  // Overflow exists exactly when the two top bits of the 17-bit sum disagree.
  function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
    logic signed [15:0] r;
    if (v[16] == v[15]) r = v[15:0];
    else if (v[16])     r = 16'sh8000;
    else                r = 16'sh7FFF;
    return r;
  endfunction

endpackage

// File: rtl/delay_addr_gen.sv
// Delay clamp and circular read-address generation for the delay line.
// Clamp works on the live delay_len; the read address uses the latched delay.
module delay_addr_gen #(
  parameter int DEPTH = 29280,
  parameter int AW    = 15
) (
  input  logic [AW-1:0] delay_len,
  input  logic [AW-1:0] wr_ptr,
  input  logic [AW-1:0] d_lat,
  output logic [AW-1:0] d_clamp,
  output logic [AW-1:0] r_addr
);

  logic [AW:0] diff;

  always_comb begin
    d_clamp = delay_len;
    if (delay_len == '0) begin
      d_clamp = AW'(1);
    end else if ({1'b0, delay_len} >= (AW+1)'(DEPTH)) begin
      d_clamp = AW'(DEPTH - 1);
    end
  end

  // wr_ptr < DEPTH and d_lat >= 1, so a single +DEPTH correction suffices.
  always_comb begin
    diff   = {1'b0, wr_ptr} - {1'b0, d_lat};
    r_addr = diff[AW-1:0];
    if (diff[AW]) begin
      r_addr = diff[AW-1:0] + AW'(DEPTH);
    end
  end

endmodule

// File: rtl/delay_line_ctrl.sv
// Circular echo/delay-line sequencer driving memory_mod: read delayed, write dry+feedback.
// Define DELAY_LINE_CTRL_FILL_EN to zero the whole memory after every reset.
module delay_line_ctrl
  import delay_line_pkg::*;
#(
  parameter int DEPTH = DL_DEPTH,
  parameter int AW    = DL_AW,
  parameter int DW    = DL_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] sample_in,
  input  logic [AW-1:0] delay_len,
  input  logic [7:0]    fb_gain,
  output logic          out_valid,
  output logic [DW-1:0] sample_out,
  output logic          busy,
  output logic          mem_w_en,
  output logic [AW-1:0] mem_w_addr,
  output logic [DW-1:0] mem_d_in,
  output logic [AW-1:0] mem_r_addr,
  input  logic [DW-1:0] mem_d_out
);

`ifdef DELAY_LINE_CTRL_FILL_EN
  localparam state_e RST_STATE = CLEAR;
`else
  localparam state_e RST_STATE = IDLE;
`endif

  state_e               state_q, state_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        d_q, d_d;
  logic [AW-1:0]        d_clamp, r_addr;
  logic signed [DW-1:0] x_q, x_d;
  logic [7:0]           gain_q, gain_d;
  logic signed [DW-1:0] sample_out_q, sample_out_d;
  logic                 out_valid_q, out_valid_d;
  logic signed [DW-1:0] y, fb, wr_data;
  logic signed [DW+8:0] prod;
  logic signed [DW:0]   sum;
  logic                 w_en_raw;
`ifdef DELAY_LINE_CTRL_FILL_EN
  logic [AW-1:0]        clr_q, clr_d;
`endif

  delay_addr_gen #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_addr_gen (
    .delay_len (delay_len),
    .wr_ptr    (wr_ptr_q),
    .d_lat     (d_q),
    .d_clamp   (d_clamp),
    .r_addr    (r_addr)
  );

  // Feedback path: y*gain is at most 24 significant bits; >>>8 keeps bits [23:8].
  always_comb begin
    y       = $signed(mem_d_out);
    prod    = (DW+9)'(y) * (DW+9)'($signed({1'b0, gain_q}));
    fb      = prod[DW+7:8];
    sum     = {x_q[DW-1], x_q} + {fb[DW-1], fb};
    wr_data = sat16(sum);
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    d_d          = d_q;
    x_d          = x_q;
    gain_d       = gain_q;
    sample_out_d = sample_out_q;
    out_valid_d  = 1'b0;
`ifdef DELAY_LINE_CTRL_FILL_EN
    clr_d        = clr_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = $signed(sample_in);
          gain_d  = fb_gain;
          d_d     = d_clamp;
          state_d = RD;
        end
      end
      RD: state_d = WR;
      WR: begin
        sample_out_d = y;
        out_valid_d  = 1'b1;
        wr_ptr_d     = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        state_d      = IDLE;
      end
      CLEAR: begin
`ifdef DELAY_LINE_CTRL_FILL_EN
        clr_d = clr_q + AW'(1);
        if (clr_q == AW'(DEPTH - 1)) begin
          clr_d   = '0;
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RST_STATE;
      wr_ptr_q     <= '0;
      out_valid_q  <= 1'b0;
      sample_out_q <= '0;
`ifdef DELAY_LINE_CTRL_FILL_EN
      clr_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      out_valid_q  <= out_valid_d;
      sample_out_q <= sample_out_d;
`ifdef DELAY_LINE_CTRL_FILL_EN
      clr_q        <= clr_d;
`endif
    end
  end

  // Per-sample operands: only meaningful after an accept, so no reset needed.
  always_ff @(posedge clk) begin
    x_q    <= x_d;
    gain_q <= gain_d;
    d_q    <= d_d;
  end

  always_comb begin
    in_ready   = (state_q == IDLE);
    busy       = (state_q != IDLE);
    out_valid  = out_valid_q;
    sample_out = sample_out_q;
    w_en_raw   = 1'b0;
    mem_w_addr = '0;
    mem_d_in   = '0;
    mem_r_addr = '0;
    case (state_q)
      RD: mem_r_addr = r_addr;
      WR: begin
        w_en_raw   = 1'b1;
        mem_w_addr = wr_ptr_q;
        mem_d_in   = wr_data;
      end
`ifdef DELAY_LINE_CTRL_FILL_EN
      CLEAR: begin
        w_en_raw   = 1'b1;
        mem_w_addr = clr_q;
      end
`endif
      default: ;
    endcase
    // A reset arriving mid-transaction must never corrupt a memory word.
    mem_w_en = w_en_raw & rst_n;
  end

endmodule
